tower_damage_queue: RTL and testbench
=====================================

// Module: tower_damage_queue
// PURPOSE
//  Upstream of the tower: gathers attack requests from NUM_UNITS on-field unit slots,
//  arbitrates them round-robin into a damage FIFO, and releases one hit per game tick to
//  the tower as a one-clk attackSCEN pulse with damageOut. Flushes on tower death or a new
//  level, so stale hits never land on a fresh tower.
// PARAMETERS
//  NUM_UNITS  4  number of unit request slots (>=2)
//  DMG_W      8  damage width; must match the tower damageIn width
//  DEPTH      8  FIFO entries (power of 2)
// PORTS
//  clk          in   1                single clock; all logic on posedge
//  reset_n      in   1                asynchronous, active-low reset
//  startLevel   in   1                pulse; begin accepting hits
//  towerDead    in   1                level from tower; stop and flush
//  gameTick     in   1                one-clk strobe (game rate), synchronous to clk
//  attackReq    in   NUM_UNITS        per-unit request, held until granted
//  attackDmg    in   NUM_UNITS*DMG_W  per-unit damage; slot i = [i*DMG_W +: DMG_W]
//  attackGrant  out  NUM_UNITS        one-hot, one-clk pulse: request accepted
//  damageOut    out  DMG_W            damage of the current hit
//  attackSCEN   out  1                one-clk strobe: apply damageOut to the tower
//  queueCount   out  log2(DEPTH)+1    FIFO occupancy
//  overflow     out  1                sticky; set on a saturated coalesce (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; FIFO empty; rr pointer=0; all outputs 0.
//  FSM:
//   IDLE   -> ACTIVE on startLevel. No grants and no pops in IDLE.
//   ACTIVE -> FLUSH on towerDead (towerDead takes priority over a same-cycle grant/pop).
//   ACTIVE -> FLUSH on startLevel (restart).
//   FLUSH: one cycle; clears FIFO, count and rr pointer; overflow is not cleared.
//          Then -> ACTIVE if startLevel is high in that cycle, otherwise -> IDLE.
//  Arbitration (ACTIVE only):
//   - At most one grant per clk. Round-robin search starts at the rr pointer.
//   - After a grant to slot i, the rr pointer moves to i+1 mod NUM_UNITS.
//   - attackGrant is combinational, same cycle as the FIFO write.
//   - Grant is allowed when count<DEPTH, or when count==DEPTH and a pop occurs that cycle.
//   - A damage-0 request is granted and discarded; it is not written to the FIFO.
//  Release:
//   - Pop occurs in ACTIVE when gameTick=1 and the registered count>0 at that edge.
//   - attackSCEN and damageOut are registered: high/valid for the one cycle after the
//     popping edge. damageOut returns to 0 when attackSCEN=0.
//   - A write and a tick in the same cycle with count==0: no pop; the entry is popped
//     on a later tick.
//   - Minimum latency: grant at edge N, tick at edge N+1, attackSCEN high during cycle N+1..N+2.
//  Arithmetic:
//   - Pointers are log2(DEPTH) bits and wrap mod DEPTH.
//   - count is updated by +1 on write, -1 on pop, unchanged on simultaneous write+pop.
//  Reset mid-operation: immediate return to the reset state; no attackSCEN glitch.
// CONFIGURATION
//  Macro TOWER_DMG_COALESCE_EN:
//   Defined:
//    - When count==DEPTH and there is no pop, the granted request is still accepted.
//    - Its damage is added to the tail entry, saturating at 2^DMG_W-1.
//    - If saturation clips the sum, overflow is set (sticky until reset).
//    - Grants are never stalled.
//   Undefined:
//    - When count==DEPTH and there is no pop, no grant; requesters keep attackReq asserted.
//    - overflow is tied to 0.
// TESTING
//  T1: reset_n=0 mid-ACTIVE with 3 entries queued -> count=0, attackSCEN=0, IDLE.
//      After release, no pop without startLevel.
//  T2: startLevel; unit0 req dmg=10; tick on the next clk -> grant0 pulse.
//      attackSCEN=1 with damageOut=10 for exactly one cycle.
//  T3: all 4 units request continuously (dmg 1,2,3,4), no ticks.
//      Grants go 0,1,2,3,0,1,2,3 until count=8, then stall (macro off).
//      Draining ticks then output 1,2,3,4,1,2,3,4.
//  T4: macro on, FIFO full with tail=250; unit2 req dmg=20 -> grant2 pulse, tail=255,
//      overflow=1, count stays 8.
//  T5: count=5, towerDead=1 together with req+tick -> no grant, no attackSCEN,
//      count=0 after FLUSH, state=IDLE.
//  T6: count=8 (macro off), req+tick in the same cycle -> grant issued, pop issued,
//      count stays 8; FIFO order preserved across pointer wrap.

Source files
------------

// File: rtl/tower_damage_queue.sv
// Round-robin gatherer of unit attack requests into a damage FIFO, released one hit per game tick.
// Optional TOWER_DMG_COALESCE_EN: when full with no pop, merge new damage into the tail (saturating).
module tower_damage_queue #(
  parameter int NUM_UNITS = 4,
  parameter int DMG_W     = 8,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       startLevel,
  input  logic                       towerDead,
  input  logic                       gameTick,
  input  logic [NUM_UNITS-1:0]       attackReq,
  input  logic [NUM_UNITS*DMG_W-1:0] attackDmg,
  output logic [NUM_UNITS-1:0]       attackGrant,
  output logic [DMG_W-1:0]           damageOut,
  output logic                       attackSCEN,
  output logic [$clog2(DEPTH):0]     queueCount,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int UW = $clog2(NUM_UNITS);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t            state_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [UW-1:0]     rr_r;
  logic [DMG_W-1:0]  mem_r [DEPTH];

  logic              found_s;
  logic [UW-1:0]     gidx_s;
  logic [DMG_W-1:0]  gdmg_s;
  logic              run_s;
  logic              pop_s;
  logic              full_s;
  logic              grant_ok_s;
  logic              grant_s;
  logic              wr_s;
  logic [AW-1:0]     tail_ptr_s;
  logic [DMG_W:0]    sum_s;
  logic [DMG_W-1:0]  coal_val_s;
  logic              coal_s;
  logic              sat_s;

  // Round-robin search for the first requester at or after the rr pointer.
  always_comb begin : rr_search
    int idx;
    idx     = 0;
    found_s = 1'b0;
    gidx_s  = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx = int'(rr_r) + k;
      if (idx >= NUM_UNITS) begin
        idx = idx - NUM_UNITS;
      end else begin
        idx = idx;
      end
      if (!found_s && attackReq[idx]) begin
        found_s = 1'b1;
        gidx_s  = UW'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant, write, pop and coalesce decisions; death or restart suppresses all traffic.
  always_comb begin
    gdmg_s     = attackDmg[int'(gidx_s)*DMG_W +: DMG_W];
    run_s      = (state_r == ACTIVE) && !towerDead && !startLevel;
    full_s     = (count_r == FULL_C);
    pop_s      = run_s && gameTick && (count_r != '0);
`ifdef TOWER_DMG_COALESCE_EN
    grant_ok_s = 1'b1;
`else
    grant_ok_s = !full_s || pop_s;
`endif
    grant_s    = run_s && found_s && grant_ok_s;
    wr_s       = grant_s && (gdmg_s != '0) && (!full_s || pop_s);
    coal_s     = grant_s && (gdmg_s != '0) && full_s && !pop_s;
    tail_ptr_s = wr_ptr_r - AW'(1);
    sum_s      = {1'b0, mem_r[tail_ptr_s]} + {1'b0, gdmg_s};
    sat_s      = sum_s[DMG_W];
    if (sat_s) begin
      coal_val_s = '1;
    end else begin
      coal_val_s = sum_s[DMG_W-1:0];
    end
    if (grant_s) begin
      attackGrant = {{(NUM_UNITS-1){1'b0}}, 1'b1} << gidx_s;
    end else begin
      attackGrant = '0;
    end
  end

  // FIFO storage; a coalesce only happens when full with no pop, never alongside a write.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= gdmg_s;
    end else if (coal_s) begin
      mem_r[tail_ptr_s] <= coal_val_s;
    end
  end

  // Level FSM, FIFO pointers/count, rr pointer and registered hit outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      rr_r       <= '0;
      attackSCEN <= 1'b0;
      damageOut  <= '0;
    end else begin
      attackSCEN <= pop_s;
      damageOut  <= pop_s ? mem_r[rd_ptr_r] : '0;
      case (state_r)
        IDLE: begin
          if (startLevel) state_r <= ACTIVE;
        end
        ACTIVE: begin
          if (towerDead || startLevel) begin
            state_r <= FLUSH;
          end else begin
            if (wr_s)  wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({wr_s, pop_s})
              2'b10:   count_r <= count_r + CW'(1);
              2'b01:   count_r <= count_r - CW'(1);
              default: count_r <= count_r;
            endcase
            if (grant_s) begin
              rr_r <= (gidx_s == UW'(NUM_UNITS-1)) ? '0 : gidx_s + UW'(1);
            end
          end
        end
        FLUSH: begin
          wr_ptr_r <= '0;
          rd_ptr_r <= '0;
          count_r  <= '0;
          rr_r     <= '0;
          state_r  <= startLevel ? ACTIVE : IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef TOWER_DMG_COALESCE_EN
  logic overflow_r;

  // Sticky saturation flag; survives flushes, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
    end else if (coal_s && sat_s) begin
      overflow_r <= 1'b1;
    end
  end

  assign overflow = overflow_r;
`else
  assign overflow = 1'b0;
`endif

  assign queueCount = count_r;

endmodule

// File: tb/tb_tower_damage_queue.sv
// Directed self-checking bench for tower_damage_queue (default 4 units, 8-bit damage, depth 8).
module tb_tower_damage_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        startLevel;
  logic        towerDead;
  logic        gameTick;
  logic [3:0]  attackReq;
  logic [31:0] attackDmg;
  logic [3:0]  attackGrant;
  logic [7:0]  damageOut;
  logic        attackSCEN;
  logic [3:0]  queueCount;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  tower_damage_queue #(.NUM_UNITS(4), .DMG_W(8), .DEPTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .startLevel  (startLevel),
    .towerDead   (towerDead),
    .gameTick    (gameTick),
    .attackReq   (attackReq),
    .attackDmg   (attackDmg),
    .attackGrant (attackGrant),
    .damageOut   (damageOut),
    .attackSCEN  (attackSCEN),
    .queueCount  (queueCount),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    startLevel = 1'b1;
    cyc();
    startLevel = 1'b0;
  endtask

  task automatic flush_to_idle();
    towerDead = 1'b1;
    cyc();
    towerDead = 1'b0;
    cyc();
  endtask

  task automatic push(input int u, input int d, input string tag);
    attackDmg = '0;
    attackDmg[u*8 +: 8] = 8'(d);
    attackReq = 4'(1 << u);
    #1;
    chk(tag, 32'(attackGrant), 32'(1 << u));
    cyc();
    attackReq = '0;
  endtask

  initial begin
    reset_n = 1'b0; startLevel = 1'b0; towerDead = 1'b0; gameTick = 1'b0;
    attackReq = '0; attackDmg = '0;
    repeat (3) cyc();
    chk("rst_count", 32'(queueCount), 32'd0);
    chk("rst_scen", 32'(attackSCEN), 32'd0);
    chk("rst_dmg", 32'(damageOut), 32'd0);
    chk("rst_grant", 32'(attackGrant), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    cyc();

    // IDLE ignores requests
    attackReq = 4'b0001; attackDmg = 32'd5;
    #1;
    chk("idle_grant", 32'(attackGrant), 32'd0);
    attackReq = '0;
    cyc();

    // T2: minimum latency single hit
    start();
    push(0, 10, "t2_grant");
    gameTick = 1'b1;
    cyc();
    gameTick = 1'b0;
    chk("t2_scen", 32'(attackSCEN), 32'd1);
    chk("t2_dmg", 32'(damageOut), 32'd10);
    chk("t2_count", 32'(queueCount), 32'd0);
    cyc();
    chk("t2_scen_off", 32'(attackSCEN), 32'd0);
    chk("t2_dmg_off", 32'(damageOut), 32'd0);

    // T3: round-robin fill then ordered drain
    flush_to_idle();
    start();
    attackDmg = {8'd4, 8'd3, 8'd2, 8'd1};
    attackReq = 4'hF;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t3_grant", 32'(attackGrant), 32'(1 << (i % 4)));
      cyc();
    end
    chk("t3_full", 32'(queueCount), 32'd8);
`ifndef TOWER_DMG_COALESCE_EN
    #1;
    chk("t3_stall", 32'(attackGrant), 32'd0);
    cyc();
    chk("t3_stall_count", 32'(queueCount), 32'd8);
`endif
    attackReq = '0;
    gameTick = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t3_scen", 32'(attackSCEN), 32'd1);
      chk("t3_dmg", 32'(damageOut), 32'((i % 4) + 1));
    end
    gameTick = 1'b0;
    cyc();
    chk("t3_scen_end", 32'(attackSCEN), 32'd0);
    chk("t3_empty", 32'(queueCount), 32'd0);

    // zero damage: granted but discarded
    push(1, 0, "zero_grant");
    chk("zero_count", 32'(queueCount), 32'd0);

    // T6: offset the pointers, fill, then req+tick at full across the wrap
    push(0, 11, "t6_pre"); push(0, 12, "t6_pre"); push(0, 13, "t6_pre");
    chk("t6_pre_count", 32'(queueCount), 32'd3);
    gameTick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_pre_dmg", 32'(damageOut), 32'(11 + i));
    end
    gameTick = 1'b0;
    for (int i = 0; i < 8; i++) push(0, 21 + i, "t6_fill");
    chk("t6_full", 32'(queueCount), 32'd8);
    gameTick = 1'b1;
    push(1, 99, "t6_grant");
    chk("t6_scen", 32'(attackSCEN), 32'd1);
    chk("t6_dmg", 32'(damageOut), 32'd21);
    chk("t6_count", 32'(queueCount), 32'd8);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("t6_order", 32'(damageOut), (i < 7) ? 32'(22 + i) : 32'd99);
    end
    gameTick = 1'b0;
    cyc();
    chk("t6_empty", 32'(queueCount), 32'd0);
    chk("t6_scen_end", 32'(attackSCEN), 32'd0);

`ifdef TOWER_DMG_COALESCE_EN
    // T4: saturated coalesce into the tail
    for (int i = 0; i < 7; i++) push(0, 1, "t4_fill");
    push(0, 250, "t4_tail");
    chk("t4_full", 32'(queueCount), 32'd8);
    push(2, 20, "t4_grant");
    chk("t4_count", 32'(queueCount), 32'd8);
    chk("t4_ovf", 32'(overflow), 32'd1);
    gameTick = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 7) chk("t4_tail_dmg", 32'(damageOut), 32'd255);
    end
    gameTick = 1'b0;
    cyc();
`else
    chk("ovf_tied", 32'(overflow), 32'd0);
`endif

    // T5: towerDead beats a same-cycle request and tick
    for (int i = 0; i < 5; i++) push(0, i + 1, "t5_fill");
    chk("t5_count5", 32'(queueCount), 32'd5);
    towerDead = 1'b1; gameTick = 1'b1;
    attackDmg = 32'd7; attackReq = 4'b0001;
    #1;
    chk("t5_grant", 32'(attackGrant), 32'd0);
    cyc();
    chk("t5_scen", 32'(attackSCEN), 32'd0);
    towerDead = 1'b0; gameTick = 1'b0; attackReq = '0;
    cyc();
    chk("t5_count", 32'(queueCount), 32'd0);
    chk("t5_scen2", 32'(attackSCEN), 32'd0);
    attackReq = 4'b0001; gameTick = 1'b1;
    #1;
    chk("t5_idle_grant", 32'(attackGrant), 32'd0);
    cyc();
    chk("t5_idle_scen", 32'(attackSCEN), 32'd0);
    attackReq = '0; gameTick = 1'b0;

    // restart: startLevel in ACTIVE flushes, held high through FLUSH goes back to ACTIVE
    start();
    push(0, 9, "rs_fill");
    startLevel = 1'b1;
    cyc();
    cyc();
    startLevel = 1'b0;
    chk("rs_count", 32'(queueCount), 32'd0);
    push(0, 4, "rs_grant");
    chk("rs_count1", 32'(queueCount), 32'd1);

    // T1: asynchronous reset mid-ACTIVE with entries queued
    push(0, 5, "t1_fill"); push(0, 6, "t1_fill");
    chk("t1_count3", 32'(queueCount), 32'd3);
    gameTick = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    chk("t1_count", 32'(queueCount), 32'd0);
    chk("t1_scen", 32'(attackSCEN), 32'd0);
    cyc();
    chk("t1_scen_rst", 32'(attackSCEN), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t1_no_pop", 32'(attackSCEN), 32'd0);
    end
    attackReq = 4'b0001; attackDmg = 32'd5;
    #1;
    chk("t1_idle_grant", 32'(attackGrant), 32'd0);
    attackReq = '0; gameTick = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
